dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the CPU load/store stage and a debug/program-loader port fed from the UART side of Riscv151. Performs one access per cycle. The CPU has priority by default. A starvation counter forces a debug access when the CPU monopolises the memory, and a lock mode lets the loader hold the memory for bulk writes while the CPU stalls. Read data returns one cycle after grant, matching the synchronous-read dmem array.

## Interface
- `ADDR_WIDTH`, 14: word address width (dmem word index).
- `DATA_WIDTH`, 32: data word width.
- `STARVE_LIMIT`, 8: consecutive denied debug-request cycles before a forced debug grant; legal range 1..255.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_req` in 1: CPU access request this cycle.
- `cpu_we` in 4: CPU byte write enables; 0 means read.
- `cpu_addr` in ADDR_WIDTH: CPU word address.
- `cpu_wdata` in DATA_WIDTH: CPU write data.
- `cpu_stall` out 1: CPU request not served this cycle; pipeline must hold.
- `cpu_rdata` out DATA_WIDTH: CPU read data.
- `cpu_rvalid` out 1: `cpu_rdata` valid.
- `dbg_req` in 1: debug access request.
- `dbg_lock` in 1: keep ownership after this grant.
- `dbg_we` in 4: debug byte write enables.
- `dbg_addr` in ADDR_WIDTH: debug word address.
- `dbg_wdata` in DATA_WIDTH: debug write data.
- `dbg_gnt` out 1: debug request served this cycle.
- `dbg_rdata` out DATA_WIDTH: debug read data.
- `dbg_rvalid` out 1: `dbg_rdata` valid.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 4: memory byte write enables.
- `mem_addr` out ADDR_WIDTH: memory word address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_rdata` in DATA_WIDTH: memory read data, valid the cycle after a read access.

## Operation
- States: CPU_PRI (reset state), DBG_FORCE, DBG_LOCK. Winner selection is combinational from state and requests. `mem_*` is muxed from the winner. `mem_en` = a winner exists.
- CPU_PRI:
  - `cpu_req` wins if high, else `dbg_req` wins.
  - `starve_cnt` (8 bits) increments when `dbg_req` is high and the CPU wins. It clears on any debug grant or when `dbg_req` is low.
  - When the increment makes `starve_cnt` equal `STARVE_LIMIT`, go to DBG_FORCE.
- DBG_FORCE:
  - If `dbg_req` is high, debug wins and `cpu_stall` = `cpu_req`. Next state is DBG_LOCK if `dbg_lock` is high, else CPU_PRI.
  - If `dbg_req` is low, the CPU wins as in CPU_PRI, and the next state is CPU_PRI.
- Any debug grant with `dbg_lock`=1 in any state moves to DBG_LOCK and clears `starve_cnt`.
- DBG_LOCK:
  - Debug is the only eligible requester.
  - `mem_en` = `dbg_req`.
  - `cpu_stall` = `cpu_req` every cycle, including idle debug cycles.
  - When `dbg_lock` is sampled low, go to CPU_PRI. That cycle's `dbg_req` is still served.
- `cpu_stall` = `cpu_req` AND NOT CPU-wins.
- `dbg_gnt` = `dbg_req` AND debug-wins.
- Read tracking:
  - Registered `rd_owner` and `rd_pending` are set when the winner issues a read (`we`=0).
  - In the next cycle the matching `*_rvalid` is 1 and `*_rdata` = `mem_rdata`. The non-owner's rdata is held at 0.
- Writes produce no response. Byte enables pass through unmodified; partial-word merge belongs to the memory.
- Reset asserted mid-operation (any state, including DBG_LOCK or a pending read):
  - State returns to CPU_PRI, `starve_cnt` to 0, and `rd_pending` to 0 immediately.
  - The pending read's rvalid is never issued.

## Timing
- Reset values:
  - `cpu_rvalid`=0, `dbg_rvalid`=0, `cpu_rdata`=0, `dbg_rdata`=0.
  - `mem_en`, `cpu_stall`, `dbg_gnt` follow requests combinationally (CPU_PRI rules).
- Grant, stall, and the `mem_*` drive occur in the same cycle as the request, with zero latency.
- Read latency: the rvalid pulse lasts exactly one cycle, one cycle after the grant.
- Back-to-back reads from alternating owners each return in order, one per cycle.
- Simultaneous requests in CPU_PRI below the limit: CPU is served, debug is denied, and the counter advances.
- Write followed by a read of the same address in the next cycle returns the new data; the memory guarantees this.
- With `STARVE_LIMIT`=N and both requesters continuously high: the CPU is served N cycles, then debug is served 1 cycle, repeating with period N+1.

## Test plan
- CPU alone: write 0xDEADBEEF with `cpu_we`=4'hF to addr 0, then read addr 0. Required: `cpu_stall`=0 throughout, and `cpu_rvalid`=1 with 0xDEADBEEF one cycle after the read grant.
- Contention with `STARVE_LIMIT`=4 and both requests held high for 15 cycles. Required: `dbg_gnt` high on cycles 5, 10, 15 only, and `cpu_stall` high exactly on those cycles.
- Lock burst: debug writes 0x11, 0x22, 0x33 to addr 1..3 with `dbg_lock`=1 on the first two while `cpu_req` is high. Required:
  - `cpu_stall`=1 for all three cycles and 0 on the fourth.
  - CPU reads of addr 1..3 then return 0x11, 0x22, 0x33.
- Byte enables: write 0xAABBCCDD, then CPU write with `cpu_we`=4'b0010 and data 0x0000EE00. Required: a readback of 0xAABBEEDD.
- Reset mid-lock: in DBG_LOCK, issue a debug read and pull `rst_n` low asynchronously mid-cycle. Required:
  - `dbg_rvalid` stays 0.
  - After release, `cpu_req` alone gets `cpu_stall`=0 on the first cycle.
- Idle: both requests low. Required: `mem_en`=0, both rvalids 0, and `starve_cnt` stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous-read data memory between
// the CPU load/store stage and the debug/program-loader port.
// The CPU has priority. A starvation counter forces a debug grant after
// STARVE_LIMIT consecutive denied debug cycles. A lock mode lets the loader
// hold the memory for bulk transfers while the CPU stalls.
// Read data is returned one cycle after the grant, tagged by owner.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // CPU load/store port
    input  logic                  cpu_req,
    input  logic [3:0]            cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    // Debug / program-loader port
    input  logic                  dbg_req,
    input  logic                  dbg_lock,
    input  logic [3:0]            dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_rvalid,
    // Memory port
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_CPU_PRI   = 2'd0;
    localparam logic [1:0] ST_DBG_FORCE = 2'd1;
    localparam logic [1:0] ST_DBG_LOCK  = 2'd2;

    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    logic [7:0] starve_cnt_r;
    logic [7:0] starve_cnt_nx_s;
    logic [7:0] starve_inc_s;
    logic       cpu_win_s;
    logic       dbg_win_s;
    logic       rd_pending_r;
    logic       rd_owner_r;      // 1 = debug owns the outstanding read
    logic       rd_issue_s;

    // Winner selection from the current state and this cycle's requests.
    always_comb begin
        cpu_win_s = 1'b0;
        dbg_win_s = 1'b0;
        case (state_r)
            ST_CPU_PRI: begin
                if (cpu_req) begin
                    cpu_win_s = 1'b1;
                end else begin
                    dbg_win_s = dbg_req;
                end
            end
            ST_DBG_FORCE: begin
                if (dbg_req) begin
                    dbg_win_s = 1'b1;
                end else begin
                    cpu_win_s = cpu_req;
                end
            end
            ST_DBG_LOCK: begin
                // Only the loader may use the memory while locked.
                dbg_win_s = dbg_req;
            end
            default: begin
                if (cpu_req) begin
                    cpu_win_s = 1'b1;
                end else begin
                    dbg_win_s = dbg_req;
                end
            end
        endcase
    end

    // Memory port mux driven by the winner; idle when nobody wins.
    always_comb begin
        mem_en    = cpu_win_s | dbg_win_s;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_win_s) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_win_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_we    = 4'b0000;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_win_s;
    assign dbg_gnt    = dbg_req & dbg_win_s;
    assign rd_issue_s = mem_en & (mem_we == 4'b0000);

    // Next state and starvation counter.
    always_comb begin
        starve_inc_s    = starve_cnt_r + 8'd1;
        starve_cnt_nx_s = starve_cnt_r;
        state_nx_s      = state_r;

        // Counter runs only while debug is actively being denied.
        if (dbg_win_s) begin
            starve_cnt_nx_s = 8'd0;
        end else if (!dbg_req) begin
            starve_cnt_nx_s = 8'd0;
        end else if (cpu_win_s && (state_r == ST_CPU_PRI)) begin
            starve_cnt_nx_s = starve_inc_s;
        end else begin
            starve_cnt_nx_s = starve_cnt_r;
        end

        case (state_r)
            ST_CPU_PRI: begin
                if (dbg_win_s && dbg_lock) begin
                    state_nx_s = ST_DBG_LOCK;
                end else if (cpu_win_s && dbg_req && (starve_inc_s == LIMIT_C)) begin
                    state_nx_s = ST_DBG_FORCE;
                end else begin
                    state_nx_s = ST_CPU_PRI;
                end
            end
            ST_DBG_FORCE: begin
                if (dbg_win_s && dbg_lock) begin
                    state_nx_s = ST_DBG_LOCK;
                end else begin
                    state_nx_s = ST_CPU_PRI;
                end
            end
            ST_DBG_LOCK: begin
                // The cycle that drops dbg_lock is still served, then release.
                if (dbg_lock) begin
                    state_nx_s = ST_DBG_LOCK;
                end else begin
                    state_nx_s = ST_CPU_PRI;
                end
            end
            default: begin
                state_nx_s = ST_CPU_PRI;
            end
        endcase
    end

    // Arbitration state and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_CPU_PRI;
            starve_cnt_r <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            starve_cnt_r <= starve_cnt_nx_s;
        end
    end

    // Outstanding-read tracking so the response reaches the right port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_r <= 1'b0;
            rd_owner_r   <= 1'b0;
        end else begin
            rd_pending_r <= rd_issue_s;
            rd_owner_r   <= dbg_win_s;
        end
    end

    // Read response steering; the non-owner sees zero data.
    always_comb begin
        cpu_rvalid = rd_pending_r & ~rd_owner_r;
        dbg_rvalid = rd_pending_r & rd_owner_r;
        if (cpu_rvalid) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = '0;
        end
        if (dbg_rvalid) begin
            dbg_rdata = mem_rdata;
        end else begin
            dbg_rdata = '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous-read memory model.
module tb_dmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          dbg_req;
    logic          dbg_lock;
    logic [3:0]    dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks_q;
    int failures_q;

    logic [DW-1:0] mem_q [0:15];

    dmem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .dbg_req   (dbg_req),
        .dbg_lock  (dbg_lock),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rdata (dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with byte enables and synchronous read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) mem_q[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem_q[mem_addr[3:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            failures_q++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic [3:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic lk, input logic [3:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req = req; dbg_lock = lk; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic prev_cpu;
        logic prev_dbg;
        logic exp_g;
        checks_q   = 0;
        failures_q = 0;
        mem_rdata  = '0;
        for (int i = 0; i < 16; i++) mem_q[i] = '0;
        rst_n = 1'b0;
        set_cpu(1'b0, 4'h0, 14'd0, 32'd0);
        set_dbg(1'b0, 1'b0, 4'h0, 14'd0, 32'd0);

        // Reset state
        #3;
        chk("rst_mem_en", mem_en, 32'd0);
        chk("rst_cpu_rvalid", cpu_rvalid, 32'd0);
        chk("rst_dbg_rvalid", dbg_rvalid, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        cpu_req = 1'b1;
        #1;
        chk("rst_cpu_stall", cpu_stall, 32'd0);
        chk("rst_mem_en_req", mem_en, 32'd1);
        cpu_req = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // CPU alone: write then read back
        set_cpu(1'b1, 4'hF, 14'd0, 32'hDEADBEEF);
        sample();
        chk("cpu_wr_stall", cpu_stall, 32'd0);
        chk("cpu_wr_mem_we", mem_we, 32'hF);
        chk("cpu_wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        next_cyc();
        set_cpu(1'b1, 4'h0, 14'd0, 32'd0);
        sample();
        chk("cpu_rd_stall", cpu_stall, 32'd0);
        chk("cpu_wr_no_rvalid", cpu_rvalid, 32'd0);
        next_cyc();
        set_cpu(1'b0, 4'h0, 14'd0, 32'd0);
        sample();
        chk("cpu_rd_rvalid", cpu_rvalid, 32'd1);
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_rd_dbg_rvalid", dbg_rvalid, 32'd0);
        chk("cpu_rd_dbg_rdata", dbg_rdata, 32'd0);
        next_cyc();

        // Contention, limit 4: debug served on cycles 5, 10, 15
        prev_cpu = 1'b0;
        prev_dbg = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            set_cpu(1'b1, 4'h0, 14'd0, 32'd0);
            set_dbg(1'b1, 1'b0, 4'h0, 14'd0, 32'd0);
            exp_g = (i % 5 == 0);
            sample();
            chk($sformatf("cont_gnt_%0d", i), dbg_gnt, {31'd0, exp_g});
            chk($sformatf("cont_stall_%0d", i), cpu_stall, {31'd0, exp_g});
            chk($sformatf("cont_cpu_rv_%0d", i), cpu_rvalid, {31'd0, prev_cpu});
            chk($sformatf("cont_dbg_rv_%0d", i), dbg_rvalid, {31'd0, prev_dbg});
            prev_cpu = ~exp_g;
            prev_dbg = exp_g;
            next_cyc();
        end
        set_cpu(1'b0, 4'h0, 14'd0, 32'd0);
        set_dbg(1'b0, 1'b0, 4'h0, 14'd0, 32'd0);
        sample();
        chk("cont_last_dbg_rv", dbg_rvalid, 32'd1);
        chk("cont_last_dbg_rd", dbg_rdata, 32'hDEADBEEF);
        next_cyc();

        // Counter clears when debug drops its request
        for (int i = 1; i <= 9; i++) begin
            set_cpu(1'b1, 4'h0, 14'd0, 32'd0);
            set_dbg((i != 4), 1'b0, 4'h0, 14'd0, 32'd0);
            exp_g = (i == 9);
            sample();
            chk($sformatf("clr_gnt_%0d", i), dbg_gnt, {31'd0, exp_g});
            next_cyc();
        end

        // Lock burst: enter lock with a debug read, then three writes
        set_cpu(1'b0, 4'h0, 14'd0, 32'd0);
        set_dbg(1'b1, 1'b1, 4'h0, 14'd0, 32'd0);
        sample();
        chk("lk_enter_gnt", dbg_gnt, 32'd1);
        next_cyc();
        for (int i = 1; i <= 3; i++) begin
            set_cpu(1'b1, 4'h0, 14'd5, 32'd0);
            set_dbg(1'b1, (i != 3), 4'hF, 14'(i), 32'(i * 17));
            sample();
            chk($sformatf("lk_stall_%0d", i), cpu_stall, 32'd1);
            chk($sformatf("lk_gnt_%0d", i), dbg_gnt, 32'd1);
            chk($sformatf("lk_addr_%0d", i), {18'd0, mem_addr}, 32'(i));
            if (i == 1) chk("lk_dbg_rd", dbg_rdata, 32'hDEADBEEF);
            next_cyc();
        end
        for (int i = 1; i <= 4; i++) begin
            set_cpu((i != 4), 4'h0, 14'(i), 32'd0);
            set_dbg(1'b0, 1'b0, 4'h0, 14'd0, 32'd0);
            sample();
            if (i == 1) chk("lk_rel_stall", cpu_stall, 32'd0);
            if (i > 1) chk($sformatf("lk_rd_%0d", i - 1), cpu_rdata, 32'((i - 1) * 17));
            next_cyc();
        end

        // Byte-enable partial write
        set_cpu(1'b1, 4'hF, 14'd4, 32'hAABBCCDD);
        next_cyc();
        set_cpu(1'b1, 4'b0010, 14'd4, 32'h0000EE00);
        sample();
        chk("be_mem_we", mem_we, 32'h2);
        next_cyc();
        set_cpu(1'b1, 4'h0, 14'd4, 32'd0);
        next_cyc();
        set_cpu(1'b0, 4'h0, 14'd0, 32'd0);
        sample();
        chk("be_rdata", cpu_rdata, 32'hAABBEEDD);
        next_cyc();

        // Reset in the middle of a locked debug read
        set_dbg(1'b1, 1'b1, 4'h0, 14'd4, 32'd0);
        sample();
        chk("rl_enter_gnt", dbg_gnt, 32'd1);
        next_cyc();
        set_cpu(1'b1, 4'h0, 14'd1, 32'd0);
        set_dbg(1'b1, 1'b1, 4'h0, 14'd1, 32'd0);
        sample();
        chk("rl_lock_stall", cpu_stall, 32'd1);
        chk("rl_prev_rvalid", dbg_rvalid, 32'd1);
        chk("rl_prev_rdata", dbg_rdata, 32'hAABBEEDD);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rl_rst_rvalid", dbg_rvalid, 32'd0);
        chk("rl_rst_stall", cpu_stall, 32'd0);
        chk("rl_rst_gnt", dbg_gnt, 32'd0);
        next_cyc();
        chk("rl_after_edge_rvalid", dbg_rvalid, 32'd0);
        rst_n = 1'b1;
        set_dbg(1'b0, 1'b0, 4'h0, 14'd0, 32'd0);
        sample();
        chk("rl_cpu_stall", cpu_stall, 32'd0);
        chk("rl_cpu_mem_en", mem_en, 32'd1);
        chk("rl_no_dbg_rvalid", dbg_rvalid, 32'd0);
        next_cyc();
        set_cpu(1'b0, 4'h0, 14'd0, 32'd0);
        sample();
        chk("rl_cpu_rdata", cpu_rdata, 32'h00000011);
        next_cyc();

        // Idle
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("idle_mem_en", mem_en, 32'd0);
            chk("idle_cpu_rv", cpu_rvalid, 32'd0);
            chk("idle_dbg_rv", dbg_rvalid, 32'd0);
            chk("idle_starve", dut.starve_cnt_r, 32'd0);
            next_cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
